mem_arbiter: RTL

Two-port arbiter and sequencer for the shared 1 KB byte-addressable data memory: it accepts fetch requests and load/store requests, picks at most one per cycle by round-robin, and drives the memory's single address/byte-enable/sign-extension control set. Sits between the core's fetch and load/store units and the `mem` instance. It translates access size and signedness into byte enables, rejects misaligned or out-of-range accesses without touching memory, and returns registered responses through a valid/ready handshake with backpressure.

---
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/load-store arbiter and sequencer for the shared data memory
module mem_arbiter #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    output logic        if_rsp_valid,
    input  logic        if_rsp_ready,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,

    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic        ls_req_we,
    input  logic [1:0]  ls_req_size,
    input  logic        ls_req_unsigned,
    input  logic [31:0] ls_req_addr,
    input  logic [31:0] ls_req_wdata,
    output logic        ls_rsp_valid,
    input  logic        ls_rsp_ready,
    output logic [31:0] ls_rsp_rdata,
    output logic        ls_rsp_err,

    output logic [31:0] mem_adrs_rd,
    output logic [31:0] mem_adrs_wr,
    input  logic [31:0] mem_rd_data,
    output logic        mem_wr_en,
    output logic [3:0]  mem_byt_en,
    output logic        mem_sign_ext,
    output logic [31:0] mem_wr_data
);

    // One past the last valid byte; end addresses are compared in 33 bits so
    // an access near 0xFFFFFFFF cannot wrap back into range.
    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    logic        rr;
    logic        if_free;
    logic        ls_free;
    logic        if_elig;
    logic        ls_elig;
    logic        grant_if;
    logic        grant_ls;

    logic [32:0] if_end;
    logic        if_err;

    logic [2:0]  ls_bytes;
    logic [3:0]  ls_be;
    logic        ls_misalign;
    logic [32:0] ls_end;
    logic        ls_err;

    // Fetch is always an aligned word read; flag misalignment or overrun.
    always_comb begin
        if_end = {1'b0, if_req_addr} + 33'd4;
        if_err = (if_req_addr[1:0] != 2'b00) || (if_end > MEM_LIMIT);
    end

    // Translate load/store size into byte count and enables, and flag bad accesses.
    always_comb begin
        ls_bytes    = 3'd4;
        ls_be       = 4'b1111;
        ls_misalign = 1'b0;
        case (ls_req_size)
            2'b00: begin
                ls_bytes = 3'd1;
                ls_be    = 4'b0001;
            end
            2'b01: begin
                ls_bytes    = 3'd2;
                ls_be       = 4'b0011;
                ls_misalign = ls_req_addr[0];
            end
            2'b10: begin
                ls_misalign = (ls_req_addr[1:0] != 2'b00);
            end
            default: begin
                // Size 11 has no encoding; treat it like a misaligned access.
                ls_misalign = 1'b1;
            end
        endcase
        ls_end = {1'b0, ls_req_addr} + {30'd0, ls_bytes};
        ls_err = ls_misalign || (ls_end > MEM_LIMIT);
    end

    // Pick at most one requester per cycle; nothing is granted while in reset
    // so a store arriving with rst cannot reach the memory.
    always_comb begin
        if_free  = !if_rsp_valid || if_rsp_ready;
        ls_free  = !ls_rsp_valid || ls_rsp_ready;
        if_elig  = if_req_valid && if_free && !rst;
        ls_elig  = ls_req_valid && ls_free && !rst;
        grant_if = if_elig && (!ls_elig || !rr);
        grant_ls = ls_elig && (!if_elig || rr);
        if_req_ready = grant_if;
        ls_req_ready = grant_ls;
    end

    // Drive the single memory control set from the granted, error-free request.
    always_comb begin
        mem_adrs_rd  = 32'd0;
        mem_adrs_wr  = 32'd0;
        mem_wr_en    = 1'b0;
        mem_byt_en   = 4'b0000;
        mem_sign_ext = 1'b0;
        mem_wr_data  = 32'd0;
        if (grant_if && !if_err) begin
            mem_adrs_rd = if_req_addr;
            mem_byt_en  = 4'b1111;
        end else if (grant_ls && !ls_err) begin
            mem_byt_en = ls_be;
            if (ls_req_we) begin
                mem_adrs_wr = ls_req_addr;
                mem_wr_data = ls_req_wdata;
                mem_wr_en   = 1'b1;
            end else begin
                mem_adrs_rd  = ls_req_addr;
                mem_sign_ext = !ls_req_unsigned;
            end
        end
    end

    // Fetch response register: load on grant, drain on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= 32'd0;
            if_rsp_err   <= 1'b0;
        end else if (grant_if) begin
            if_rsp_valid <= 1'b1;
            if_rsp_data  <= if_err ? 32'd0 : mem_rd_data;
            if_rsp_err   <= if_err;
        end else if (if_rsp_valid && if_rsp_ready) begin
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= 32'd0;
            if_rsp_err   <= 1'b0;
        end
    end

    // Load/store response register; stores respond with zero data.
    always_ff @(posedge clk) begin
        if (rst) begin
            ls_rsp_valid <= 1'b0;
            ls_rsp_rdata <= 32'd0;
            ls_rsp_err   <= 1'b0;
        end else if (grant_ls) begin
            ls_rsp_valid <= 1'b1;
            ls_rsp_rdata <= (ls_err || ls_req_we) ? 32'd0 : mem_rd_data;
            ls_rsp_err   <= ls_err;
        end else if (ls_rsp_valid && ls_rsp_ready) begin
            ls_rsp_valid <= 1'b0;
            ls_rsp_rdata <= 32'd0;
            ls_rsp_err   <= 1'b0;
        end
    end

    // Round-robin pointer: after a grant, favour the other requester; LS first out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= 1'b1;
        end else if (grant_if) begin
            rr <= 1'b1;
        end else if (grant_ls) begin
            rr <= 1'b0;
        end
    end

endmodule
